eu_fetch_sched: RTL and testbench
=================================

Name: eu_fetch_sched

Overview:
- Parametrised fetch scheduler for the execution-unit array. It sits between the control unit's eu_fetch/eu_fetch_addr strobes and the per-group EU wrappers.
- Fetch requests from any number of groups are queued per group. A round-robin arbiter grants the single SDRAM read port to one group at a time.
- It drives the read-mux select and launches the group's fetch. It holds the grant until that group reports done, with timeout and collision error reporting.
- Replaces fixed-group fetch wiring with N-group arbitrated, serialised fetch.

Parameters:
- NUM_GROUPS, 3, number of EU groups sharing the SDRAM read port.
- SUB_NUM, 4, sub-units per group; group g owns control bits [g*SUB_NUM +: SUB_NUM].
- CTRL_W, 32, width of the eu_fetch control word; elaboration error if NUM_GROUPS*SUB_NUM > CTRL_W.
- ADDR_W, 32, fetch address width.
- TIMEOUT_W, 16, width of the timeout counter and limit.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- eu_fetch  in  CTRL_W  one-cycle request pulses, one bit per sub-unit; bits above NUM_GROUPS*SUB_NUM are ignored.
- eu_fetch_addr  in  ADDR_W  address, sampled with any eu_fetch bit.
- grp_fetch  out  NUM_GROUPS*SUB_NUM  one-cycle launch pulse to the granted group's sub-units.
- grp_fetch_addr  out  ADDR_W  address for the launch; stable from LAUNCH until the next LAUNCH.
- grp_fetch_done  in  NUM_GROUPS  per-group level, high when that group's fetch is complete or idle.
- rd_sel  out  $clog2(NUM_GROUPS) (min 1)  SDRAM read mux select.
- timeout_limit  in  TIMEOUT_W  maximum WAIT_DONE cycles; 0 disables the timeout.
- err_clr  in  1  clears the sticky errors.
- fetch_done  out  1  high when no request is pending and no fetch is active.
- busy  out  1  high when state is not IDLE.
- err_timeout  out  1  sticky.
- err_collision  out  1  sticky.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all pend_mask=0, pend_addr=0; rr pointer=0.
  - grp_fetch=0, grp_fetch_addr=0, rd_sel=0, fetch_done=1, busy=0, both errors=0, timeout counter=0.
  - A reset mid-fetch drops every pending and active request.
- Pending capture, every cycle, per group g:
  - new_g = eu_fetch[g*SUB_NUM +: SUB_NUM].
  - pend_mask_g <= (pend_mask_g & ~clr_g) | new_g.
  - If new_g != 0, pend_addr_g <= eu_fetch_addr.
  - If new_g != 0 and the surviving pend_mask_g != 0, set err_collision. The masks merge and the newest address wins.
  - clr_g is high only in the cycle group g is selected (IDLE->LAUNCH). New bits arriving that same cycle are kept.
- Arbitration: in IDLE, if any pend_mask != 0, pick the first pending group at or after rr pointer (wrapping modulo NUM_GROUPS). Latch its mask/addr, clear it, set rr = sel+1 (wrapping), go to LAUNCH.
- FSM:
  - IDLE -> LAUNCH: as described under Arbitration.
  - LAUNCH (1 cycle): rd_sel=sel, grp_fetch[sel*SUB_NUM +: SUB_NUM]=latched mask (all other bits 0), grp_fetch_addr=latched addr. Then go to SETTLE.
  - SETTLE (1 cycle): grp_fetch_done is ignored. Then go to WAIT_DONE.
  - WAIT_DONE: the counter increments each cycle.
    - If grp_fetch_done[sel]=1, go to IDLE.
    - Else if timeout_limit!=0 and counter == timeout_limit-1, set err_timeout and go to IDLE (request dropped).
    - Done wins over timeout in the same cycle. The counter clears on leaving WAIT_DONE.
- rd_sel: updated on entry to LAUNCH and held otherwise, including in IDLE.
- Outputs: all registered.
- Latency:
  - A request pulse in cycle 0 with the scheduler idle gives grp_fetch high in cycle 2.
  - Back-to-back grants: IDLE costs one cycle between WAIT_DONE exit and the next LAUNCH.
- fetch_done (registered): equals (next state==IDLE) && all next pend_mask==0. It is 0 in the cycle after any accepted request.
- Errors: sticky until err_clr. If err_clr and a set event coincide, the set wins.

Decomposition:
- Package eu_sched_pkg: state enum (IDLE, LAUNCH, SETTLE, WAIT_DONE) and a grp_idx width helper function.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs gnt_idx and gnt_valid. Purely combinational, reusable elsewhere.

Test Plan:
- Single request: eu_fetch=0x0000_0020, addr=0x1000, idle.
  - Cycle 2: grp_fetch=0x020, rd_sel=1, grp_fetch_addr=0x1000.
  - After grp_fetch_done[1] rises: fetch_done=1 and busy=0 on the following cycle.
- Simultaneous groups: eu_fetch=0x111 in one cycle.
  - Launches go in order g0, g1, g2, each waiting for its done.
  - rd_sel sequence 0,1,2; no collision error.
- Round-robin fairness: g0 re-requests each time it completes while g2 is pending.
  - After g0 completes, g2 is granted before g0 again.
- Collision: two pulses to g0 (0x1 @ A, then 0x2 @ B) while g1 is active.
  - g0 launch carries mask 0x3 with addr B; err_collision=1 until err_clr.
- Timeout: timeout_limit=8, done held low.
  - err_timeout sets after exactly 8 WAIT_DONE cycles, then returns to IDLE.
  - With timeout_limit=0 the scheduler waits indefinitely.
- Reset during WAIT_DONE with requests pending:
  - All outputs at reset values immediately (async).
  - No launches after reset release without a new request.

Source files
------------

// File: rtl/eu_fetch_sched_pkg.sv
// Shared types for the EU fetch scheduler: FSM state encoding and the
// helper that sizes group-index fields.
package eu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        SETTLE    = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

    // Width of a group index; never narrower than one bit.
    function automatic int grp_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eu_fetch_sched_if.sv
// Fetch bus between the control unit, the scheduler and the EU group wrappers.
// The scheduler uses the master view; the CU/EU side uses the slave view.
interface eu_fetch_sched_if
    import eu_sched_pkg::*;
#(
    parameter int NUM_GROUPS = 3,
    parameter int SUB_NUM    = 4,
    parameter int CTRL_W     = 32,
    parameter int ADDR_W     = 32
) ();

    localparam int GW = NUM_GROUPS * SUB_NUM;
    localparam int IW = grp_idx_w(NUM_GROUPS);

    logic [CTRL_W-1:0]     eu_fetch;
    logic [ADDR_W-1:0]     eu_fetch_addr;
    logic [GW-1:0]         grp_fetch;
    logic [ADDR_W-1:0]     grp_fetch_addr;
    logic [NUM_GROUPS-1:0] grp_fetch_done;
    logic [IW-1:0]         rd_sel;

    modport master (
        input  eu_fetch,
        input  eu_fetch_addr,
        input  grp_fetch_done,
        output grp_fetch,
        output grp_fetch_addr,
        output rd_sel
    );

    modport slave (
        output eu_fetch,
        output eu_fetch_addr,
        output grp_fetch_done,
        input  grp_fetch,
        input  grp_fetch_addr,
        input  rd_sel
    );

endinterface

// File: rtl/eu_fetch_sched_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    int            j;
    logic [IW-1:0] idx;

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = 0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            idx = IW'(j);
            if (req[idx]) begin
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eu_fetch_sched.sv
// N-group fetch scheduler: queues per-group fetch requests, round-robin grants
// the shared SDRAM read port and holds it until the group reports done.
module eu_fetch_sched
    import eu_sched_pkg::*;
#(
    parameter int NUM_GROUPS = 3,
    parameter int SUB_NUM    = 4,
    parameter int CTRL_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eu_fetch_sched_if.master     bus,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    input  logic                 err_clr,
    output logic                 fetch_done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_collision
);

    localparam int GW = NUM_GROUPS * SUB_NUM;
    localparam int IW = grp_idx_w(NUM_GROUPS);

    if (GW > CTRL_W) begin : g_width_chk
        $error("eu_fetch_sched: NUM_GROUPS*SUB_NUM exceeds CTRL_W");
    end

    sched_state_e          state, state_nxt;
    logic [SUB_NUM-1:0]    pend_mask     [NUM_GROUPS];
    logic [ADDR_W-1:0]     pend_addr     [NUM_GROUPS];
    logic [SUB_NUM-1:0]    pend_mask_nxt [NUM_GROUPS];
    logic [SUB_NUM-1:0]    new_mask      [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] req;
    logic [NUM_GROUPS-1:0] collide;
    logic                  pend_any_nxt;
    logic [IW-1:0]         rr_ptr, rr_nxt, gnt_idx;
    logic                  gnt_valid, take, tmo_hit;
    logic [GW-1:0]         launch_vec;
    logic [TIMEOUT_W-1:0]  tmo_cnt;
    logic                  unused_ctrl;

    // Control bits beyond the last group are accepted and ignored.
    assign unused_ctrl = ^bus.eu_fetch;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_req
        assign new_mask[g] = bus.eu_fetch[g*SUB_NUM +: SUB_NUM];
        assign req[g]      = |pend_mask[g];
    end

    rr_arbiter #(.N(NUM_GROUPS), .IW(IW)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign rr_nxt = (gnt_idx == IW'(NUM_GROUPS - 1)) ? '0 : gnt_idx + IW'(1);

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    take      = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH:  state_nxt = SETTLE;
            SETTLE:  state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                // Done has priority over a timeout landing in the same cycle.
                if (bus.grp_fetch_done[bus.rd_sel]) begin
                    state_nxt = IDLE;
                end else if (timeout_limit != '0 &&
                             tmo_cnt == timeout_limit - TIMEOUT_W'(1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The granted group's pending bits are cleared while bits arriving in
    // the same cycle survive; a new pulse onto a still-pending group collides.
    always_comb begin
        pend_any_nxt = 1'b0;
        collide      = '0;
        launch_vec   = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            pend_mask_nxt[g] = (take && gnt_idx == IW'(g)) ? new_mask[g]
                                                            : (pend_mask[g] | new_mask[g]);
            collide[g]       = (|new_mask[g]) && (|pend_mask[g]) &&
                               !(take && gnt_idx == IW'(g));
            pend_any_nxt     = pend_any_nxt | (|pend_mask_nxt[g]);
            if (gnt_idx == IW'(g)) launch_vec[g*SUB_NUM +: SUB_NUM] = pend_mask[g];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            tmo_cnt            <= '0;
            bus.grp_fetch      <= '0;
            bus.grp_fetch_addr <= '0;
            bus.rd_sel         <= '0;
            fetch_done         <= 1'b1;
            busy               <= 1'b0;
            err_timeout        <= 1'b0;
            err_collision      <= 1'b0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                pend_mask[g] <= '0;
                pend_addr[g] <= '0;
            end
        end else begin
            state <= state_nxt;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                pend_mask[g] <= pend_mask_nxt[g];
                if (|new_mask[g]) pend_addr[g] <= bus.eu_fetch_addr;
            end
            bus.grp_fetch <= '0;
            if (take) begin
                bus.grp_fetch      <= launch_vec;
                bus.grp_fetch_addr <= pend_addr[gnt_idx];
                bus.rd_sel         <= gnt_idx;
                rr_ptr             <= rr_nxt;
            end
            tmo_cnt       <= (state == WAIT_DONE && state_nxt == WAIT_DONE) ?
                             tmo_cnt + TIMEOUT_W'(1) : '0;
            fetch_done    <= (state_nxt == IDLE) && !pend_any_nxt;
            busy          <= (state_nxt != IDLE);
            err_timeout   <= (err_timeout & ~err_clr) | tmo_hit;
            err_collision <= (err_collision & ~err_clr) | (|collide);
        end
    end

endmodule

// File: tb/tb_eu_fetch_sched.sv
// Scenario bench for eu_fetch_sched: a scoreboard of expected launches plus a
// small EU model that drops done on launch and raises it after a set latency.
module tb_eu_fetch_sched;
    import eu_sched_pkg::*;

    typedef struct {
        logic [11:0] mask;
        logic [31:0] addr;
        logic [1:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] eu_fetch = '0;
    logic [31:0] eu_fetch_addr = '0;
    logic [15:0] timeout_limit = '0;
    logic        err_clr = 1'b0;
    logic        fetch_done, busy, err_timeout, err_collision;
    logic [2:0]  eu_done = '1;
    int          lat [3] = '{2, 2, 2};
    int          cnt [3] = '{0, 0, 0};
    int          checks = 0;
    int          errors = 0;
    int          launches = 0;
    exp_t        exp_q [$];
    exp_t        e;

    always #5 clk = ~clk;

    eu_fetch_sched_if #(.NUM_GROUPS(3), .SUB_NUM(4), .CTRL_W(32), .ADDR_W(32)) bus ();

    assign bus.eu_fetch       = eu_fetch;
    assign bus.eu_fetch_addr  = eu_fetch_addr;
    assign bus.grp_fetch_done = eu_done;

    eu_fetch_sched #(
        .NUM_GROUPS(3), .SUB_NUM(4), .CTRL_W(32), .ADDR_W(32), .TIMEOUT_W(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .timeout_limit (timeout_limit),
        .err_clr       (err_clr),
        .fetch_done    (fetch_done),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_collision (err_collision)
    );

    // Launch monitor against the scoreboard, plus the EU done model.
    always @(negedge clk) begin
        if (!rst_n) begin
            eu_done = '1;
            for (int g = 0; g < 3; g++) cnt[g] = 0;
        end else begin
            for (int g = 0; g < 3; g++)
                if (cnt[g] > 0) begin
                    cnt[g]--;
                    if (cnt[g] == 0) eu_done[g] = 1'b1;
                end
            if (bus.grp_fetch !== 12'h000) begin
                launches++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL launch_unexpected got grp_fetch=%h rd_sel=%0d", bus.grp_fetch, bus.rd_sel);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.grp_fetch !== e.mask || bus.grp_fetch_addr !== e.addr || bus.rd_sel !== e.sel) begin
                        errors++;
                        $display("FAIL launch got mask=%h addr=%h sel=%0d exp mask=%h addr=%h sel=%0d",
                                 bus.grp_fetch, bus.grp_fetch_addr, bus.rd_sel, e.mask, e.addr, e.sel);
                    end
                end
                if (bus.rd_sel <= 2'd2) begin
                    eu_done[bus.rd_sel] = 1'b0;
                    cnt[bus.rd_sel]     = lat[bus.rd_sel];
                end
            end
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        eu_fetch = '0;
        err_clr  = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [11:0] m, input logic [31:0] a, input logic [1:0] s);
        exp_t x;
        x.mask = m; x.addr = a; x.sel = s;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.grp_fetch !== 12'h0 || bus.grp_fetch_addr !== 32'h0 || bus.rd_sel !== 2'd0 ||
            fetch_done !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0 || err_collision !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got gf=%h ga=%h sel=%0d fd=%b busy=%b et=%b ec=%b exp 0/0/0/1/0/0/0",
                     bus.grp_fetch, bus.grp_fetch_addr, bus.rd_sel, fetch_done, busy, err_timeout, err_collision);
        end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        lat = '{2, 3, 2};
        push_exp(12'h020, 32'h1000, 2'd1);
        eu_fetch = 32'h0000_0020; eu_fetch_addr = 32'h1000;
        @(negedge clk);
        eu_fetch = '0;
        checks++;
        if (fetch_done !== 1'b0 || bus.grp_fetch !== 12'h0) begin
            errors++;
            $display("FAIL single_cycle1 got fd=%b gf=%h exp fd=0 gf=000", fetch_done, bus.grp_fetch);
        end
        @(negedge clk);
        checks++;
        if (bus.grp_fetch !== 12'h020 || bus.rd_sel !== 2'd1 || bus.grp_fetch_addr !== 32'h1000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_cycle2 got gf=%h sel=%0d addr=%h busy=%b exp 020/1/00001000/1",
                     bus.grp_fetch, bus.rd_sel, bus.grp_fetch_addr, busy);
        end
        n = 0;
        @(posedge clk);
        while (eu_done[1] !== 1'b1 && n < 50) begin @(posedge clk); n++; end
        @(negedge clk);
        checks++;
        if (fetch_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got fd=%b busy=%b exp fd=1 busy=0", fetch_done, busy);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (fetch_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (fetch_done !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_idle got fd=%b queued=%0d exp fd=1 queued=0", tag, fetch_done, exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        lat = '{2, 2, 2};
        push_exp(12'h001, 32'h2000, 2'd0);
        push_exp(12'h010, 32'h2000, 2'd1);
        push_exp(12'h100, 32'h2000, 2'd2);
        eu_fetch = 32'h111; eu_fetch_addr = 32'h2000;
        @(negedge clk);
        eu_fetch = '0;
        wait_idle("simul");
        checks++;
        if (err_collision !== 1'b0) begin
            errors++;
            $display("FAIL simul_collision got %b exp 0", err_collision);
        end
    endtask

    task automatic test_rr_fair();
        do_reset();
        lat = '{4, 2, 2};
        push_exp(12'h001, 32'hA0, 2'd0);
        push_exp(12'h100, 32'hA2, 2'd2);
        push_exp(12'h001, 32'hB0, 2'd0);
        eu_fetch = 32'h001; eu_fetch_addr = 32'hA0;
        @(negedge clk);
        eu_fetch = 32'h100; eu_fetch_addr = 32'hA2;
        @(negedge clk);
        eu_fetch = '0;
        @(negedge clk);
        eu_fetch = 32'h001; eu_fetch_addr = 32'hB0;
        @(negedge clk);
        eu_fetch = '0;
        wait_idle("rr");
        checks++;
        if (err_collision !== 1'b0) begin
            errors++;
            $display("FAIL rr_collision got %b exp 0", err_collision);
        end
    endtask

    task automatic test_collision();
        do_reset();
        lat = '{2, 6, 2};
        push_exp(12'h010, 32'hC1, 2'd1);
        push_exp(12'h003, 32'hBBBB, 2'd0);
        eu_fetch = 32'h010; eu_fetch_addr = 32'hC1;
        @(negedge clk);
        eu_fetch = '0;
        @(negedge clk);
        eu_fetch = 32'h001; eu_fetch_addr = 32'hAAAA;
        @(negedge clk);
        eu_fetch = 32'h002; eu_fetch_addr = 32'hBBBB;
        checks++;
        if (err_collision !== 1'b0) begin
            errors++;
            $display("FAIL coll_first got %b exp 0", err_collision);
        end
        @(negedge clk);
        eu_fetch = '0;
        checks++;
        if (err_collision !== 1'b1) begin
            errors++;
            $display("FAIL coll_set got %b exp 1", err_collision);
        end
        wait_idle("coll");
        checks++;
        if (err_collision !== 1'b1) begin
            errors++;
            $display("FAIL coll_sticky got %b exp 1", err_collision);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_collision !== 1'b0) begin
            errors++;
            $display("FAIL coll_clear got %b exp 0", err_collision);
        end
    endtask

    task automatic test_timeout_and_reset();
        int snap;
        do_reset();
        lat = '{0, 2, 2};
        timeout_limit = 16'd8;
        push_exp(12'h001, 32'hD0, 2'd0);
        eu_fetch = 32'h001; eu_fetch_addr = 32'hD0;
        @(negedge clk);
        eu_fetch = '0;
        @(negedge clk);
        repeat (9) @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early got et=%b busy=%b exp et=0 busy=1", err_timeout, busy);
        end
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || fetch_done !== 1'b1) begin
            errors++;
            $display("FAIL tmo_fire got et=%b busy=%b fd=%b exp 1/0/1", err_timeout, busy, fetch_done);
        end
        timeout_limit = 16'd0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear got %b exp 0", err_timeout);
        end
        push_exp(12'h001, 32'hD1, 2'd0);
        eu_fetch = 32'h001; eu_fetch_addr = 32'hD1;
        @(negedge clk);
        eu_fetch = '0;
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_disabled got busy=%b et=%b exp busy=1 et=0", busy, err_timeout);
        end
        eu_fetch = 32'h110; eu_fetch_addr = 32'hE0;
        @(negedge clk);
        eu_fetch = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.grp_fetch !== 12'h0 || bus.grp_fetch_addr !== 32'h0 || bus.rd_sel !== 2'd0 ||
            fetch_done !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0 || err_collision !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got gf=%h ga=%h sel=%0d fd=%b busy=%b exp 0/0/0/1/0",
                     bus.grp_fetch, bus.grp_fetch_addr, bus.rd_sel, fetch_done, busy);
        end
        exp_q.delete();
        snap = launches;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (launches != snap || busy !== 1'b0 || fetch_done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got launches=%0d busy=%b fd=%b exp launches=%0d busy=0 fd=1",
                     launches, busy, fetch_done, snap);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_rr_fair();
        test_collision();
        test_timeout_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "bench time limit");
    end

endmodule
